// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   localparam int DIV_WIDTH_DEFAULT = 8;
   localparam int DIV_CNT_W         = $clog2(DIV_WIDTH_DEFAULT + 1);

   function automatic int div_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring step: shift in a dividend bit, trial-subtract the divisor.
module divider_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted_s;
   logic           ge_s;

   // A set rem_i MSB means the shifted value overflowed WIDTH+1 bits and is certainly >= divisor.
   always_comb begin
      shifted_s = {rem_i[WIDTH-1:0], bit_i};
      ge_s      = rem_i[WIDTH] | (shifted_s >= {1'b0, divisor_i});
      q_o       = ge_s;
      if (ge_s) begin
         rem_o = shifted_s - {1'b0, divisor_i};
      end else begin
         rem_o = shifted_s;
      end
   end

endmodule

// File: rtl/divider_u8.sv
// Sequential unsigned divider, one quotient bit per clock with start/ok/err handshake.
// Optional DIVIDER_FAST_PATH_EN: A < B completes straight from IDLE without iterating.
module divider_u8
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] R,
   output logic             ok,
   output logic             err
);

   localparam int CW = div_cnt_width(WIDTH);

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;

   logic [WIDTH:0]   step_rem_s;
   logic             step_q_s;

   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .bit_i     (quo_q[WIDTH-1]),
      .divisor_i (div_q),
      .rem_o     (step_rem_s),
      .q_o       (step_q_s)
   );

   // quo_q starts as the dividend and fills with quotient bits from the LSB as it shifts out.
   always_comb begin
      state_d = state_q;
      quo_d   = quo_q;
      div_d   = div_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      r_d     = r_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               quo_d = A;
               div_d = B;
               rem_d = '0;
               cnt_d = CW'(WIDTH);
               if (B == '0) begin
                  d_d     = '1;
                  r_d     = A;
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end
`ifdef DIVIDER_FAST_PATH_EN
               else if (A < B) begin
                  d_d     = '0;
                  r_d     = A;
                  ok_d    = 1'b1;
                  state_d = ST_DONE;
               end
`endif
               else begin
                  state_d = ST_BUSY;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            rem_d = step_rem_s;
            quo_d = {quo_q[WIDTH-2:0], step_q_s};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               d_d     = {quo_q[WIDTH-2:0], step_q_s};
               r_d     = step_rem_s[WIDTH-1:0];
               ok_d    = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         quo_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         d_q     <= '0;
         r_q     <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         r_q     <= r_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   assign D   = d_q;
   assign R   = r_q;
   assign ok  = ok_q;
   assign err = err_q;

endmodule

// File: tb/tb_divider_u8.sv
// Directed self-checking bench for divider_u8 (default or DIVIDER_FAST_PATH_EN build).
`timescale 1ns/1ps
module tb_divider_u8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] A = 8'd0;
   logic [7:0] B = 8'd0;
   logic [7:0] D;
   logic [7:0] R;
   logic       ok;
   logic       err;

   int checks = 0;
   int errors = 0;

   divider_u8 #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .D     (D),
      .R     (R),
      .ok    (ok),
      .err   (err)
   );

   always #5 clk = ~clk;

   // Called at a negedge: present operands for one edge, then scramble them.
   task automatic kick(input logic [7:0] a, input logic [7:0] b);
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = ~a;
      B = 8'd0;
   endtask

   // Returns edge index (0 = accept edge) of the first ok/err cycle, -1 on timeout.
   task automatic wait_done(output int edge_n, output logic [7:0] d_v, output logic [7:0] r_v,
                            output logic ok_v, output logic err_v);
      edge_n = -1;
      d_v = 8'd0; r_v = 8'd0; ok_v = 1'b0; err_v = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (ok || err) begin
            edge_n = c;
            d_v = D; r_v = R; ok_v = ok; err_v = err;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({D, R, ok, err} !== 18'd0) begin
         errors++;
         $display("FAIL reset_values: got D=%0d R=%0d ok=%b err=%b, want all 0", D, R, ok, err);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_divide;
      logic [7:0] va [3] = '{8'd200, 8'd255, 8'd255};
      logic [7:0] vb [3] = '{8'd7,   8'd1,   8'd255};
      logic [7:0] vd [3] = '{8'd28,  8'd255, 8'd1};
      logic [7:0] vr [3] = '{8'd4,   8'd0,   8'd0};
      int e; logic [7:0] dv, rv; logic okv, errv;
      for (int i = 0; i < 3; i++) begin
         kick(va[i], vb[i]);
         wait_done(e, dv, rv, okv, errv);
         checks++;
         if (e !== 8 || okv !== 1'b1 || errv !== 1'b0) begin
            errors++;
            $display("FAIL div_timing[%0d]: got edge=%0d ok=%b err=%b, want edge=8 ok=1 err=0", i, e, okv, errv);
         end
         checks++;
         if (dv !== vd[i] || rv !== vr[i]) begin
            errors++;
            $display("FAIL div_result[%0d]: got D=%0d R=%0d, want D=%0d R=%0d", i, dv, rv, vd[i], vr[i]);
         end
         @(negedge clk);
         checks++;
         if (ok !== 1'b0 || err !== 1'b0 || D !== vd[i] || R !== vr[i]) begin
            errors++;
            $display("FAIL div_pulse_hold[%0d]: got ok=%b err=%b D=%0d R=%0d, want ok=0 err=0 D=%0d R=%0d",
                     i, ok, err, D, R, vd[i], vr[i]);
         end
      end
   endtask

   task automatic test_div_zero;
      int e; logic [7:0] dv, rv; logic okv, errv;
      kick(8'd13, 8'd0);
      wait_done(e, dv, rv, okv, errv);
      checks++;
      if (e !== 0 || errv !== 1'b1 || okv !== 1'b0) begin
         errors++;
         $display("FAIL divzero_timing: got edge=%0d err=%b ok=%b, want edge=0 err=1 ok=0", e, errv, okv);
      end
      checks++;
      if (dv !== 8'hFF || rv !== 8'd13) begin
         errors++;
         $display("FAIL divzero_result: got D=%0d R=%0d, want D=255 R=13", dv, rv);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || ok !== 1'b0) begin
         errors++;
         $display("FAIL divzero_pulse: got err=%b ok=%b one cycle later, want 0 0", err, ok);
      end
   endtask

   task automatic test_reset_mid_busy;
      int e; logic [7:0] dv, rv; logic okv, errv;
      kick(8'd200, 8'd7);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({D, R, ok, err} !== 18'd0) begin
         errors++;
         $display("FAIL reset_mid_busy: got D=%0d R=%0d ok=%b err=%b, want all 0", D, R, ok, err);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      kick(8'd7, 8'd2);
      wait_done(e, dv, rv, okv, errv);
      checks++;
      if (e !== 8 || okv !== 1'b1 || dv !== 8'd3 || rv !== 8'd1) begin
         errors++;
         $display("FAIL after_reset_div: got edge=%0d ok=%b D=%0d R=%0d, want edge=8 ok=1 D=3 R=1", e, okv, dv, rv);
      end
      @(negedge clk);
   endtask

   task automatic test_fast_path;
      int e; logic [7:0] dv, rv; logic okv, errv;
      int exp_e;
`ifdef DIVIDER_FAST_PATH_EN
      exp_e = 0;
`else
      exp_e = 8;
`endif
      kick(8'd3, 8'd9);
      wait_done(e, dv, rv, okv, errv);
      checks++;
      if (e !== exp_e || okv !== 1'b1 || errv !== 1'b0 || dv !== 8'd0 || rv !== 8'd3) begin
         errors++;
         $display("FAIL small_dividend: got edge=%0d ok=%b err=%b D=%0d R=%0d, want edge=%0d ok=1 err=0 D=0 R=3",
                  e, okv, errv, dv, rv, exp_e);
      end
      @(negedge clk);
   endtask

   // start held, A=100, B = cycle+3; accepts happen on edges 0,10,20,30.
   task automatic test_back_to_back;
      int n_ok = 0;
      int b_acc;
      A = 8'd100;
      start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         B = 8'(i + 3);
         @(posedge clk);
         @(negedge clk);
         if (err) begin
            checks++;
            errors++;
            $display("FAIL b2b_err: err high at cycle %0d, want 0", i);
         end
         if (ok) begin
            b_acc = i - 5;
            checks++;
            if ((i - 8) % 10 != 0) begin
               errors++;
               $display("FAIL b2b_spacing: ok at edge %0d, want edges 8,18,28,38", i);
            end
            checks++;
            if (D !== 8'(100 / b_acc) || R !== 8'(100 % b_acc)) begin
               errors++;
               $display("FAIL b2b_result: edge %0d got D=%0d R=%0d, want D=%0d R=%0d (B=%0d)",
                        i, D, R, 100 / b_acc, 100 % b_acc, b_acc);
            end
            n_ok++;
         end
      end
      start = 1'b0;
      checks++;
      if (n_ok !== 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, want 4", n_ok);
      end
      repeat (12) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_divide();
      test_div_zero();
      test_reset_mid_busy();
      test_fast_path();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
